// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler sharing one sign-magnitude fixed-point multiplier among NREQ requesters.
// Define MULT_SCHED_SAT_EN to force overflowed magnitudes to all ones.
module mult_sched #(
    parameter int NREQ = 2,
    parameter int N = 32,
    parameter int FRACBITS = 20,
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_ovf,
    output logic [15:0]       ovf_cnt
);
    localparam int MW = 2*N-2;
    localparam int MH = MW-FRACBITS;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] last_grant, win, op_id;
    logic [N-1:0] op_a, op_b;
    logic [MH-1:0] mag_hi;
    logic [N-2:0] res_mag;
    logic grant, ovf, hs;

    always_comb begin
        win = last_grant;
        for (int k = NREQ; k >= 1; k--)
            if (req_valid[IW'((int'(last_grant) + k) % NREQ)]) win = IW'((int'(last_grant) + k) % NREQ);
    end

    assign grant = state == IDLE && |req_valid && !rst;
    assign rsp_valid = state == RESP;
    assign hs = rsp_valid && rsp_ready;

    // Fraction bits below FRACBITS are dropped before anything else looks at the product.
    assign mag_hi = MH'((MW'(op_a[N-2:0]) * MW'(op_b[N-2:0])) >> FRACBITS);
    assign ovf = |mag_hi[MH-1:N-1];
`ifdef MULT_SCHED_SAT_EN
    assign res_mag = ovf ? '1 : mag_hi[N-2:0];
`else
    assign res_mag = mag_hi[N-2:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: if (grant) begin
                req_ready[win] = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NREQ-1);
            op_id <= '0;
            op_a <= '0;
            op_b <= '0;
            rsp_id <= '0;
            rsp_result <= '0;
            rsp_ovf <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            if (grant) begin
                last_grant <= win;
                op_id <= win;
                op_a <= req_a[win*N +: N];
                op_b <= req_b[win*N +: N];
            end
            if (state == EXEC) begin
                rsp_result <= {op_a[N-1] ^ op_b[N-1], res_mag};
                rsp_ovf <= ovf;
                rsp_id <= op_id;
            end
            if (hs && rsp_ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed checks of grant, arithmetic, round-robin, back-pressure and reset for mult_sched.
module tb_mult_sched;
    logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
    logic [1:0] req_valid = '0, req_ready;
    logic [63:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_ovf;
    logic [0:0] rsp_id;
    logic [31:0] rsp_result;
    logic [15:0] ovf_cnt;
    int n_chk = 0, n_fail = 0;

`ifdef MULT_SCHED_SAT_EN
    localparam logic [31:0] OVF_RES = 32'h7FFFFFFF;
`else
    localparam logic [31:0] OVF_RES = 32'h7FE00000;
`endif

    mult_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE at posedge+1; ends at posedge+1 in the first RESP cycle.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] g, output logic v1, output logic v2);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        #1 g = req_ready;
        tick();
        req_valid = '0;
        req_a = '1;
        req_b = '1;
        v1 = rsp_valid;
        tick();
        v2 = rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_chk++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", rsp_result); end
        n_chk++; if (rsp_id !== 1'b0 || rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_id_ovf got %b %b exp 0 0", rsp_id, rsp_ovf); end
        n_chk++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovf_cnt got %h exp 0", ovf_cnt); end
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] g;
        logic v1, v2;
        rsp_ready = 1'b1;
        issue(0, 32'h00180000, 32'h00200000, g, v1, v2);
        n_chk++; if (g !== 2'b01) begin n_fail++; $display("FAIL basic_grant got %b exp 01", g); end
        n_chk++; if (v1 !== 1'b0 || v2 !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b%b exp 01", v1, v2); end
        n_chk++; if (rsp_result !== 32'h00300000) begin n_fail++; $display("FAIL basic_result got %h exp 00300000", rsp_result); end
        n_chk++; if (rsp_id !== 1'b0 || rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_id_ovf got %b %b exp 0 0", rsp_id, rsp_ovf); end
        tick();
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_handshake got %b exp 0", rsp_valid); end
    endtask

    task automatic test_negative();
        logic [1:0] g;
        logic v1, v2;
        issue(1, 32'h80180000, 32'h00200000, g, v1, v2);
        n_chk++; if (g !== 2'b10) begin n_fail++; $display("FAIL neg_grant got %b exp 10", g); end
        n_chk++; if (rsp_result !== 32'h80300000) begin n_fail++; $display("FAIL neg_result got %h exp 80300000", rsp_result); end
        n_chk++; if (rsp_id !== 1'b1 || rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL neg_id_ovf got %b %b exp 1 0", rsp_id, rsp_ovf); end
        tick();
        issue(0, 32'h80000000, 32'h00100000, g, v1, v2);
        n_chk++; if (rsp_result !== 32'h80000000) begin n_fail++; $display("FAIL negzero_result got %h exp 80000000", rsp_result); end
        tick();
    endtask

    task automatic test_overflow();
        logic [1:0] g;
        logic v1, v2;
        issue(1, 32'h7FF00000, 32'h00200000, g, v1, v2);
        n_chk++; if (rsp_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", rsp_ovf); end
        n_chk++; if (rsp_result !== OVF_RES) begin n_fail++; $display("FAIL ovf_result got %h exp %h", rsp_result, OVF_RES); end
        n_chk++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL ovf_cnt_pre got %h exp 0", ovf_cnt); end
        tick();
        n_chk++; if (ovf_cnt !== 16'h1) begin n_fail++; $display("FAIL ovf_cnt_post got %h exp 1", ovf_cnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = {32'h00200000, 32'h00100000};
        req_b = {32'h00100000, 32'h00100000};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (req_ready !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, exp_g[i]); end
            tick();
            n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_exec_ready%0d got %b exp 00", i, req_ready); end
            tick();
            n_chk++; if (req_ready !== 2'b00 || rsp_id !== 1'(i % 2)) begin n_fail++; $display("FAIL rr_resp%0d got ready %b id %b exp 00 %0d", i, req_ready, rsp_id, i % 2); end
            n_chk++; if (rsp_result !== (i % 2 ? 32'h00200000 : 32'h00100000)) begin n_fail++; $display("FAIL rr_result%0d got %h", i, rsp_result); end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back_stall();
        logic [1:0] g;
        logic v1, v2;
        logic [31:0] held;
        rsp_ready = 1'b0;
        issue(1, 32'h7FF00000, 32'h00200000, g, v1, v2);
        held = OVF_RES;
        req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (rsp_valid !== 1'b1 || rsp_result !== held || rsp_id !== 1'b1 || rsp_ovf !== 1'b1)
                begin n_fail++; $display("FAIL stall%0d got v %b res %h id %b ovf %b", i, rsp_valid, rsp_result, rsp_id, rsp_ovf); end
            n_chk++; if (req_ready !== 2'b00 || ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL stall_ready%0d got %b cnt %h exp 00 0", i, req_ready, ovf_cnt); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        n_chk++; if (rsp_valid !== 1'b0 || ovf_cnt !== 16'h1) begin n_fail++; $display("FAIL stall_release got v %b cnt %h exp 0 1", rsp_valid, ovf_cnt); end
        tick();
        tick();
        tick();
        n_chk++; if (rsp_valid !== 1'b0 || ovf_cnt !== 16'h1) begin n_fail++; $display("FAIL withdrawn_req got v %b cnt %h exp 0 1", rsp_valid, ovf_cnt); end
    endtask

    task automatic test_reset_exec();
        req_valid = 2'b10;
        req_a = {32'h7FF00000, 32'h0};
        req_b = {32'h00200000, 32'h0};
        tick();
        req_valid = 2'b11;
        rst = 1'b1;
        tick();
        n_chk++; if (rsp_valid !== 1'b0 || ovf_cnt !== 16'h0 || req_ready !== 2'b00)
            begin n_fail++; $display("FAIL rst_exec got v %b cnt %h ready %b exp 0 0 00", rsp_valid, ovf_cnt, req_ready); end
        req_valid = '0;
        rst = 1'b0;
        tick();
        tick();
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard got %b exp 0", rsp_valid); end
        req_valid = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_next_grant got %b exp 01", req_ready); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_round_robin();
        test_back_to_back_stall();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
